// File: rtl/dmem_line_responder.sv
// rtl/dmem_line_responder.sv - cache-line backing memory responder with fixed access latency
module dmem_line_responder #(
    parameter int LATENCY  = 10,
    parameter int DEPTH    = 512,
    parameter int LINE_W   = 256,
    parameter int ADDR_LSB = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic              busy_o
);
    localparam int IDX_W = 9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    logic [LINE_W-1:0] memory [0:DEPTH-1];

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [LINE_W-1:0] data_q, data_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;

    logic              mem_we;
    logic              mem_rd;
    logic [IDX_W-1:0]  mem_idx;
    logic [LINE_W-1:0] mem_wdata;
    logic [IDX_W-1:0]  req_idx;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:ADDR_LSB+IDX_W], addr_i[ADDR_LSB-1:0]};

    assign req_idx = addr_i[ADDR_LSB+IDX_W-1:ADDR_LSB];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        data_d    = data_q;
        mem_we    = 1'b0;
        mem_rd    = 1'b0;
        mem_idx   = idx_q;
        mem_wdata = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    idx_d   = req_idx;
                    wdata_d = data_i;
                    we_d    = write_i;
                    cnt_d   = 8'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        // No wait phase: access straight from the request inputs.
                        state_d   = S_ACK;
                        mem_idx   = req_idx;
                        mem_wdata = data_i;
                        mem_we    = write_i;
                        mem_rd    = ~write_i;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_ACK;
                    mem_we  = we_q;
                    mem_rd  = ~we_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (mem_rd) begin
            data_d = memory[mem_idx];
        end

        // Reset wins over a completing access, so no write lands.
        if (rst_i) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
            data_d  = '0;
            mem_we  = 1'b0;
        end

        ack_d  = (state_d == S_ACK);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
        we_q    <= we_d;
        data_q  <= data_d;
        ack_q   <= ack_d;
        busy_q  <= busy_d;
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            memory[mem_idx] <= mem_wdata;
        end
    end

    assign ack_o  = ack_q;
    assign data_o = data_q;
    assign busy_o = busy_q;
endmodule

// File: tb/tb_dmem_line_responder.sv
// tb/tb_dmem_line_responder.sv - self-checking bench for dmem_line_responder
module tb_dmem_line_responder;
    localparam int LATENCY = 10;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         enable_i;
    logic         write_i;
    logic         ack_o;
    logic [255:0] data_o;
    logic         busy_o;

    int n_chk  = 0;
    int n_fail = 0;

    dmem_line_responder #(.LATENCY(LATENCY)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .enable_i(enable_i),
        .write_i (write_i),
        .ack_o   (ack_o),
        .data_o  (data_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Transaction-level model: a request taken at edge t0 completes its access
    // at edge t0+LATENCY and retires at edge t0+LATENCY+1.
    logic [255:0] m_mem [0:511];
    logic [255:0] m_last;
    logic         m_active;
    int           m_t0;
    int           m_idx;
    logic         m_we;
    logic [255:0] m_wd;
    int           cyc = 0;
    logic         chk_en = 1'b0;

    always @(posedge clk_i) begin
        cyc++;
        if (rst_i) begin
            m_active = 1'b0;
            m_last   = '0;
        end else if (m_active) begin
            if (cyc == m_t0 + LATENCY) begin
                if (m_we) m_mem[m_idx] = m_wd;
                else      m_last = m_mem[m_idx];
            end else if (cyc == m_t0 + LATENCY + 1) begin
                m_active = 1'b0;
            end
        end else if (enable_i) begin
            m_active = 1'b1;
            m_t0     = cyc;
            m_idx    = int'((addr_i >> 5) % 512);
            m_we     = write_i;
            m_wd     = data_i;
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("model_busy", 256'(busy_o), 256'(m_active));
            chk("model_ack", 256'(ack_o), 256'(m_active && (cyc == m_t0 + LATENCY)));
            chk("model_data", data_o, m_last);
        end
    end

    task automatic txn(input logic w, input logic [31:0] a, input logic [255:0] d, output int lat);
        int k;
        @(negedge clk_i);
        enable_i = 1'b1;
        write_i  = w;
        addr_i   = a;
        data_i   = d;
        lat      = -1;
        k        = 0;
        while (lat < 0 && k < 40) begin
            @(negedge clk_i);
            k++;
            enable_i = 1'b0;
            if (ack_o) lat = k;
        end
        if (lat < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL txn_timeout: got no ack expected ack within 40 cycles");
        end
    endtask

    initial begin
        int lat;
        int acks;
        int last_ack;
        int gap_bad;
        int busy_bad;
        logic prev_ack;

        rst_i    = 1'b1;
        enable_i = 1'b0;
        write_i  = 1'b0;
        addr_i   = '0;
        data_i   = '0;
        for (int i = 0; i < 512; i++) m_mem[i] = '0;
        dut.memory[0] = 256'h5;   m_mem[0] = 256'h5;
        dut.memory[3] = 256'h33;  m_mem[3] = 256'h33;
        dut.memory[4] = 256'h44;  m_mem[4] = 256'h44;

        repeat (3) @(negedge clk_i);
        chk("reset_ack", 256'(ack_o), 256'h0);
        chk("reset_busy", 256'(busy_o), 256'h0);
        chk("reset_data", data_o, 256'h0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk_en = 1'b1;

        // Read latency with busy window
        @(negedge clk_i);
        enable_i = 1'b1; write_i = 1'b0; addr_i = 32'h0;
        lat = -1; busy_bad = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk_i);
            enable_i = 1'b0;
            if (ack_o && lat < 0) lat = k;
            if (busy_o != (k >= 1 && k <= 11)) busy_bad++;
            if (k == 11) chk("read0_data", data_o, 256'h5);
        end
        chk("read0_latency", 256'(lat), 256'd11);
        chk("read0_busy_window", 256'(busy_bad), 256'd0);

        // Write then read with different offset in the same line
        txn(1'b1, 32'h0000_0400, {8{32'hDEAD_BEEF}}, lat);
        chk("write32_latency", 256'(lat), 256'd11);
        @(negedge clk_i);
        chk("mem32", dut.memory[32], {8{32'hDEAD_BEEF}});
        txn(1'b0, 32'h0000_0410, '0, lat);
        chk("read32_data", data_o, {8{32'hDEAD_BEEF}});

        // Address wrap modulo 512 lines
        txn(1'b1, 32'h0000_4020, 256'hA5, lat);
        @(negedge clk_i);
        chk("wrap_mem1", dut.memory[1], 256'hA5);
        txn(1'b0, 32'h0000_0020, '0, lat);
        chk("wrap_read1", data_o, 256'hA5);
        @(negedge clk_i);
        chk("data_hold_after_write", data_o, 256'hA5);

        // Held enable: one ack every LATENCY+2 cycles, never two in a row
        @(negedge clk_i);
        enable_i = 1'b1; write_i = 1'b0; addr_i = 32'h0;
        acks = 0; last_ack = -100; gap_bad = 0; prev_ack = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk_i);
            if (ack_o) begin
                if (prev_ack) gap_bad++;
                if (acks > 0 && k - last_ack != 12) gap_bad++;
                acks++;
                last_ack = k;
            end
            prev_ack = ack_o;
        end
        enable_i = 1'b0;
        chk("held_ack_count", 256'(acks), 256'd4);
        chk("held_ack_spacing", 256'(gap_bad), 256'd0);
        for (int k = 0; k < 20 && busy_o; k++) @(negedge clk_i);
        chk("held_drain", 256'(busy_o), 256'h0);

        // Inputs changed mid-transaction are ignored
        @(negedge clk_i);
        enable_i = 1'b1; write_i = 1'b1; addr_i = 32'h40; data_i = 256'h1;
        @(negedge clk_i);
        enable_i = 1'b0; addr_i = 32'h60; data_i = 256'h2;
        lat = -1;
        for (int k = 2; k <= 14; k++) begin
            @(negedge clk_i);
            if (ack_o && lat < 0) lat = k;
        end
        chk("midchg_latency", 256'(lat), 256'd11);
        chk("midchg_mem2", dut.memory[2], 256'h1);
        chk("midchg_mem3", dut.memory[3], 256'h33);

        // Reset during a pending write drops it
        @(negedge clk_i);
        enable_i = 1'b1; write_i = 1'b1; addr_i = 32'h80; data_i = 256'h7;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_i);
            enable_i = 1'b0;
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst_busy", 256'(busy_o), 256'h0);
        acks = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk_i);
            if (ack_o) acks++;
        end
        chk("rst_no_ack", 256'(acks), 256'd0);
        chk("rst_mem4", dut.memory[4], 256'h44);
        txn(1'b0, 32'h80, '0, lat);
        chk("rst_read_latency", 256'(lat), 256'd11);
        chk("rst_read_data", data_o, 256'h44);

        repeat (3) @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
